// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one single-port memory between CPU and loader
module mem_port_arbiter #(
    parameter int WIDTH    = 32,
    parameter int ADDRSIZE = 12,
    parameter int LOCK_MAX = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0,
    input  logic                we0,
    input  logic                lock0,
    input  logic [ADDRSIZE-1:0] addr0,
    input  logic [WIDTH-1:0]    wdata0,
    output logic                gnt0,
    output logic                rvalid0,
    output logic [WIDTH-1:0]    rdata0,
    input  logic                req1,
    input  logic                we1,
    input  logic                lock1,
    input  logic [ADDRSIZE-1:0] addr1,
    input  logic [WIDTH-1:0]    wdata1,
    output logic                gnt1,
    output logic                rvalid1,
    output logic [WIDTH-1:0]    rdata1,
    output logic [ADDRSIZE-1:0] ram_addr,
    output logic [WIDTH-1:0]    ram_wdata,
    output logic                ram_we,
    input  logic [WIDTH-1:0]    ram_rdata,
    output logic [1:0]          owner
);
    localparam int CW = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;

    state_t        state, state_nx;
    logic          last, last_nx;
    logic [CW-1:0] lcnt, lcnt_nx;
    logic          rv0, rv1;
    logic          at_max, hold0, hold1, pick1;

    // Grant selection, memory mux and next ownership/starvation state
    always_comb begin
        at_max   = (lcnt == CW'(LOCK_MAX));
        hold0    = (state == OWN0) && req0 && !(at_max && req1);
        hold1    = (state == OWN1) && req1 && !(at_max && req0);
        pick1    = req1 && (!req0 || !last);
        gnt0     = !rst && (hold0 || (!hold1 && req0 && !pick1));
        gnt1     = !rst && (hold1 || (!hold0 && pick1));
        ram_addr  = gnt1 ? addr1  : gnt0 ? addr0  : '0;
        ram_wdata = gnt1 ? wdata1 : gnt0 ? wdata0 : '0;
        ram_we    = gnt1 ? we1    : gnt0 ? we0    : 1'b0;
        state_nx = IDLE;
        last_nx  = last;
        lcnt_nx  = '0;
        if (gnt0) begin
            last_nx = 1'b0;
            if (lock0) begin
                state_nx = OWN0;
                lcnt_nx  = (state == OWN0) ? lcnt + CW'(req1) : CW'(req1);
            end
        end
        if (gnt1) begin
            last_nx = 1'b1;
            if (lock1) begin
                state_nx = OWN1;
                lcnt_nx  = (state == OWN1) ? lcnt + CW'(req0) : CW'(req0);
            end
        end
    end

    // State, round-robin pointer, lock counter and read-valid pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
            lcnt  <= '0;
            rv0   <= 1'b0;
            rv1   <= 1'b0;
        end else begin
            state <= state_nx;
            last  <= last_nx;
            lcnt  <= lcnt_nx;
            rv0   <= gnt0 & ~we0;
            rv1   <= gnt1 & ~we1;
        end
    end

    // A read granted just before reset must not surface while reset is held
    assign rvalid0 = rv0 & ~rst;
    assign rvalid1 = rv1 & ~rst;
    assign rdata0  = ram_rdata;
    assign rdata1  = ram_rdata;
    assign owner   = state;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, locking, starvation and read return
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, lock0, req1, we1, lock1;
    logic [11:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;

    logic        a_gnt0, a_gnt1, a_rv0, a_rv1, a_we;
    logic [31:0] a_rd0, a_rd1, a_wd, a_rd;
    logic [11:0] a_addr;
    logic [1:0]  a_owner;
    logic        b_gnt0, b_gnt1, b_rv0, b_rv1, b_we;
    logic [31:0] b_rd0, b_rd1, b_wd, b_rd;
    logic [11:0] b_addr;
    logic [1:0]  b_owner;

    logic [31:0] mem_a [4096];
    logic [31:0] mem_b [4096];
    bit          wr_a  [4096];
    bit          wr_b  [4096];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.LOCK_MAX(8)) u8 (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(a_gnt0), .rvalid0(a_rv0), .rdata0(a_rd0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(a_gnt1), .rvalid1(a_rv1), .rdata1(a_rd1),
        .ram_addr(a_addr), .ram_wdata(a_wd), .ram_we(a_we), .ram_rdata(a_rd),
        .owner(a_owner)
    );

    mem_port_arbiter #(.LOCK_MAX(3)) u3 (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(b_gnt0), .rvalid0(b_rv0), .rdata0(b_rd0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(b_gnt1), .rvalid1(b_rv1), .rdata1(b_rd1),
        .ram_addr(b_addr), .ram_wdata(b_wd), .ram_we(b_we), .ram_rdata(b_rd),
        .owner(b_owner)
    );

    function automatic logic [31:0] pat(input logic [11:0] a);
        return {20'hABCDE, a};
    endfunction

    // Memory models: unwritten words return a fixed address-derived pattern
    always @(posedge clk) begin
        if (a_we) begin
            mem_a[a_addr] <= a_wd;
            wr_a[a_addr]  <= 1'b1;
        end
        a_rd <= wr_a[a_addr] ? mem_a[a_addr] : pat(a_addr);
    end

    always @(posedge clk) begin
        if (b_we) begin
            mem_b[b_addr] <= b_wd;
            wr_b[b_addr]  <= 1'b1;
        end
        b_rd <= wr_b[b_addr] ? mem_b[b_addr] : pat(b_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic go;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        lock0 = 1'b0; lock1 = 1'b0; addr0 = 12'h010; addr1 = 12'h020;
        wdata0 = '0; wdata1 = '0;
        for (int k = 0; k < 2; k++) begin
            go; #1;
            check("rst_gnt0", 32'(a_gnt0), 32'd0);
            check("rst_gnt1", 32'(a_gnt1), 32'd0);
            check("rst_we", 32'(a_we), 32'd0);
            check("rst_rv0", 32'(a_rv0), 32'd0);
            check("rst_rv1", 32'(a_rv1), 32'd0);
            check("rst_owner", 32'(a_owner), 32'd0);
        end
        for (int k = 1; k <= 4; k++) begin
            go;
            rst = 1'b0;
            #1;
            check("tie_gnt0", 32'(a_gnt0), 32'(k % 2));
            check("tie_gnt1", 32'(a_gnt1), 32'((k + 1) % 2));
            check("tie_addr", 32'(a_addr), (k % 2) ? 32'h010 : 32'h020);
            check("tie_b_gnt0", 32'(b_gnt0), 32'(k % 2));
            if (k == 1) begin
                check("post_rst_rv0", 32'(a_rv0), 32'd0);
                check("post_rst_rv1", 32'(a_rv1), 32'd0);
            end else if (k % 2 == 0) begin
                check("tie_rv0", 32'(a_rv0), 32'd1);
                check("tie_rd0", a_rd0, pat(12'h010));
            end else begin
                check("tie_rv1", 32'(a_rv1), 32'd1);
                check("tie_rd1", a_rd1, pat(12'h020));
            end
        end
        go;
        req0 = 1'b0; req1 = 1'b0;
        #1;
        check("tie_rv1_last", 32'(a_rv1), 32'd1);
        check("tie_rd1_last", a_rd1, pat(12'h020));
        check("tie_rv0_idle", 32'(a_rv0), 32'd0);

        go;
        req1 = 1'b1; we1 = 1'b1; addr1 = 12'h7FF; wdata1 = 32'hDEADBEEF;
        #1;
        check("wr_gnt1", 32'(a_gnt1), 32'd1);
        check("wr_we", 32'(a_we), 32'd1);
        check("wr_addr", 32'(a_addr), 32'h7FF);
        check("wr_data", a_wd, 32'hDEADBEEF);
        go;
        req1 = 1'b0; we1 = 1'b0; req0 = 1'b1; addr0 = 12'h7FF;
        #1;
        check("rd_gnt0", 32'(a_gnt0), 32'd1);
        check("rd_we", 32'(a_we), 32'd0);
        go;
        req0 = 1'b0;
        #1;
        check("rd_rv0", 32'(a_rv0), 32'd1);
        check("rd_data", a_rd0, 32'hDEADBEEF);
        check("idle_addr", 32'(a_addr), 32'd0);

        go;
        req1 = 1'b1; lock1 = 1'b1; addr1 = 12'h020; addr0 = 12'h010;
        #1;
        check("burst_gnt1_c1", 32'(b_gnt1), 32'd1);
        for (int k = 2; k <= 6; k++) begin
            go;
            req0 = 1'b1;
            #1;
            check("burst_gnt1", 32'(b_gnt1), 32'(k <= 4 || k == 6));
            check("burst_gnt0", 32'(b_gnt0), 32'(k == 5));
            if (k <= 5) check("burst_owner", 32'(b_owner), 32'd2);
            else check("burst_owner_idle", 32'(b_owner), 32'd0);
        end
        go;
        req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0; rst = 1'b1;
        go;
        rst = 1'b0;

        go;
        req0 = 1'b1; lock0 = 1'b1; req1 = 1'b1;
        #1;
        check("rel_gnt0_c1", 32'(a_gnt0), 32'd1);
        check("rel_owner_c1", 32'(a_owner), 32'd0);
        for (int k = 2; k <= 4; k++) begin
            go;
            if (k == 4) lock0 = 1'b0;
            #1;
            check("rel_gnt0", 32'(a_gnt0), 32'd1);
            check("rel_owner", 32'(a_owner), 32'd1);
        end
        go; #1;
        check("rel_gnt1", 32'(a_gnt1), 32'd1);
        check("rel_owner_idle", 32'(a_owner), 32'd0);

        go;
        req1 = 1'b0; req0 = 1'b1; addr0 = 12'h010;
        #1;
        check("mid_gnt0", 32'(a_gnt0), 32'd1);
        go;
        req0 = 1'b0; rst = 1'b1;
        #1;
        check("mid_rv0_rst", 32'(a_rv0), 32'd0);
        check("mid_gnt_rst", 32'(a_gnt0), 32'd0);
        go;
        rst = 1'b0;
        #1;
        check("mid_rv0_after", 32'(a_rv0), 32'd0);
        check("mid_owner", 32'(a_owner), 32'd0);
        go;
        req0 = 1'b1; req1 = 1'b1;
        #1;
        check("mid_last_gnt0", 32'(a_gnt0), 32'd1);
        check("mid_last_gnt1", 32'(a_gnt1), 32'd0);
        go;
        req0 = 1'b0; req1 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
